note_lane_engine: RTL and testbench
===================================

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameter LANES, default 4, number of note lanes (1..8).
REQ-002 Parameter SLOTS, default 4, concurrent notes per lane (1..16).
REQ-003 Parameter NOTE_H, default 50, note height in pixels.
REQ-004 Parameter HIT_Y / HIT_H, defaults 350 / 20, hit-bar top row and height.
REQ-005 Parameter SCREEN_H, default 480, visible rows.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse; advances all notes.
REQ-009 speed  input  4  pixels moved per frame_tick (0 = frozen).
REQ-010 spawn_valid / spawn_ready  input / output  1 / 1  spawn handshake.
REQ-011 spawn_mask  input  LANES  lanes receiving a new note (chord).
REQ-012 strum  input  1  one-cycle strum pulse (already debounced).
REQ-013 buttons  input  LANES  fret buttons held, sampled with strum.
REQ-014 rd_y  input  10  render row query.
REQ-015 rd_hit  output  LANES  lanes with a note covering rd_y, registered.
REQ-016 in_window  output  LANES  lanes with a note overlapping the hit bar.
REQ-017 hit_pulse / miss_pulse  output  1 / 1  one-cycle event flags.
REQ-018 score  output  16  accumulated score.
REQ-019 streak  output  8  consecutive hits.

Function
REQ-020 Each slot holds valid bit and signed 11-bit top row y.
REQ-021 spawn_ready SHALL be high iff every lane set in spawn_mask has a free slot; transfer on spawn_valid && spawn_ready.
REQ-022 On transfer, lowest-index free slot of each masked lane SHALL become valid with y = -NOTE_H; spawn_mask = 0 accepted, no effect.
REQ-023 On frame_tick every valid slot SHALL add speed to y; a note spawned that cycle SHALL not move.
REQ-024 A slot whose updated y >= SCREEN_H SHALL be freed and SHALL assert miss_pulse next cycle and clear streak.
REQ-025 in_window[l] SHALL be high iff some valid slot in lane l has y+NOTE_H > HIT_Y and y < HIT_Y+HIT_H; combinational from slot state.
REQ-026 On strum with in_window = 0: ignored, no pulse.
REQ-027 On strum with buttons == in_window: hit; per windowed lane free the in-window slot with greatest y; hit_pulse next cycle; streak+1 (saturate 255); score += multiplier (saturate 16'hFFFF).
REQ-028 On strum with in_window != 0 and buttons != in_window: miss_pulse next cycle, streak = 0, no slot freed.
REQ-029 Same-cycle strum and frame_tick: strum judged on pre-tick positions; hit slots freed, not moved; both hit and miss pulses may assert together.
REQ-030 rd_hit[l] SHALL equal, one cycle after rd_y, whether some valid slot has y <= rd_y < y+NOTE_H.
REQ-031 Multiple fall-off misses in one tick SHALL produce a single miss_pulse.

Reset
REQ-032 reset SHALL clear all slots, score, streak, rd_hit, hit_pulse, miss_pulse; spawn_ready high in cycle after reset.
REQ-033 reset mid-operation SHALL override same-cycle spawn, tick and strum.

Configuration
REQ-034 Macro NLE_STREAK_MULT_EN defined: multiplier = 1 for streak 0..9, 2 for 10..19, 3 for 20..29, 4 for >=30 (streak before increment).
REQ-035 Macro undefined: multiplier fixed at 1; streak still counted.

Structure
REQ-036 Package nle_pkg SHALL hold default geometry constants, the slot record typedef, and the multiplier function.
REQ-037 Sub-module nle_lane SHALL implement one lane's slot array, allocation, movement, window and render match; top instantiates LANES copies and judges strum.

Verification
REQ-038 Reset, spawn_mask=4'b0001, speed=4, 100 ticks -> y=350 in lane 0, in_window=4'b0001.
REQ-039 Note in window lane 2, strum with buttons=4'b0100 -> hit_pulse, score 0->1, streak 1, slot freed.
REQ-040 Chord 4'b0011 in window, buttons=4'b0001 -> miss_pulse, streak 0, in_window stays 4'b0011.
REQ-041 SLOTS=4 filled in lane 1, spawn_mask=4'b0010 -> spawn_ready=0; after one note falls off (y>=480) -> miss_pulse, spawn_ready=1.
REQ-042 With NLE_STREAK_MULT_EN, 12 consecutive hits -> score=14; without macro -> score=12.
REQ-043 Note at y=100, rd_y=120 -> rd_hit=lane bit one cycle later; rd_y=150 -> 0.

Source files
------------

// File: rtl/nle_pkg.sv
// Shared geometry defaults, slot record and score multiplier for the note lane engine.
// Build option: define NLE_STREAK_MULT_EN to scale hit score with the current streak.
package nle_pkg;

   localparam int NLE_LANES    = 4;
   localparam int NLE_SLOTS    = 4;
   localparam int NLE_NOTE_H   = 50;
   localparam int NLE_HIT_Y    = 350;
   localparam int NLE_HIT_H    = 20;
   localparam int NLE_SCREEN_H = 480;

`ifdef NLE_STREAK_MULT_EN
   localparam bit NLE_MULT_EN = 1'b1;
`else
   localparam bit NLE_MULT_EN = 1'b0;
`endif

   typedef struct packed {
      logic              valid;
      logic signed [10:0] y;
   } slot_t;

   // Multiplier is taken from the streak before the current hit is counted.
   function automatic logic [2:0] mult_f(input logic [7:0] streak, input bit en);
      logic [2:0] m;
      m = 3'd1;
      if (en) begin
         if (streak >= 8'd30)      m = 3'd4;
         else if (streak >= 8'd20) m = 3'd3;
         else if (streak >= 8'd10) m = 3'd2;
      end
      return m;
   endfunction

endpackage

// File: rtl/nle_if.sv
// Bus bundle between the note lane engine and its controller/renderer.
// Spawn handshake: a spawn transfers on the rising clk edge where spawn_valid && spawn_ready;
// spawn_ready depends only on spawn_mask and slot occupancy, never on spawn_valid.
interface nle_if #(parameter int LANES = 4);
   logic             frame_tick;
   logic [3:0]       speed;
   logic             spawn_valid;
   logic             spawn_ready;
   logic [LANES-1:0] spawn_mask;
   logic             strum;
   logic [LANES-1:0] buttons;
   logic [9:0]       rd_y;
   logic [LANES-1:0] rd_hit;
   logic [LANES-1:0] in_window;
   logic             hit_pulse;
   logic             miss_pulse;
   logic [15:0]      score;
   logic [7:0]       streak;

   modport master (
      output frame_tick, speed, spawn_valid, spawn_mask, strum, buttons, rd_y,
      input  spawn_ready, rd_hit, in_window, hit_pulse, miss_pulse, score, streak
   );

   modport slave (
      input  frame_tick, speed, spawn_valid, spawn_mask, strum, buttons, rd_y,
      output spawn_ready, rd_hit, in_window, hit_pulse, miss_pulse, score, streak
   );
endinterface

// File: rtl/nle_lane.sv
// One note lane: slot array, lowest-free allocation, per-tick movement with fall-off,
// hit-bar window detection and registered render-row match.
module nle_lane
   import nle_pkg::*;
#(
   parameter int SLOTS    = NLE_SLOTS,
   parameter int NOTE_H   = NLE_NOTE_H,
   parameter int HIT_Y    = NLE_HIT_Y,
   parameter int HIT_H    = NLE_HIT_H,
   parameter int SCREEN_H = NLE_SCREEN_H
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spawn,
   input  logic       frame_tick,
   input  logic [3:0] speed,
   input  logic       hit_free,
   input  logic [9:0] rd_y,
   output logic       has_free,
   output logic       in_window,
   output logic       rd_hit,
   output logic       fall_off
);

   localparam logic signed [11:0] NH     = 12'(NOTE_H);
   localparam logic signed [11:0] WIN_LO = 12'(HIT_Y);
   localparam logic signed [11:0] WIN_HI = 12'(HIT_Y + HIT_H);
   localparam logic signed [11:0] SH     = 12'(SCREEN_H);
   localparam logic signed [10:0] SPAWN_Y = -11'(NOTE_H);

   slot_t slots     [SLOTS];
   slot_t slots_nxt [SLOTS];

   int                free_idx;
   int                win_idx;
   logic              win_found;
   logic              rd_match;
   logic signed [11:0] ys;
   logic signed [11:0] best_y;
   logic signed [11:0] ny;
   logic signed [11:0] rd_s;

   assign rd_s = {2'b00, rd_y};

   // Scan: first free slot, deepest in-window slot (lowest index on ties), render match.
   always_comb begin
      has_free  = 1'b0;
      free_idx  = 0;
      in_window = 1'b0;
      win_found = 1'b0;
      win_idx   = 0;
      best_y    = '0;
      rd_match  = 1'b0;
      ys        = '0;
      for (int i = 0; i < SLOTS; i++) begin
         ys = {slots[i].y[10], slots[i].y};
         if (!slots[i].valid && !has_free) begin
            has_free = 1'b1;
            free_idx = i;
         end
         if (slots[i].valid && (ys + NH > WIN_LO) && (ys < WIN_HI)) begin
            in_window = 1'b1;
            if (!win_found || ys > best_y) begin
               win_found = 1'b1;
               best_y    = ys;
               win_idx   = i;
            end
         end
         if (slots[i].valid && (ys <= rd_s) && (rd_s < ys + NH))
            rd_match = 1'b1;
      end
   end

   // A hit slot is freed before movement; a freshly spawned slot was free, so never moves.
   always_comb begin
      fall_off = 1'b0;
      ny       = '0;
      for (int i = 0; i < SLOTS; i++) begin
         slots_nxt[i] = slots[i];
         ny = {slots[i].y[10], slots[i].y} + $signed({8'b0, speed});
         if (hit_free && win_found && i == win_idx) begin
            slots_nxt[i].valid = 1'b0;
         end else if (slots[i].valid && frame_tick) begin
            if (ny >= SH) begin
               slots_nxt[i].valid = 1'b0;
               fall_off           = 1'b1;
            end else begin
               slots_nxt[i].y = ny[10:0];
            end
         end
         if (spawn && has_free && i == free_idx) begin
            slots_nxt[i].valid = 1'b1;
            slots_nxt[i].y     = SPAWN_Y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
         rd_hit <= 1'b0;
      end else begin
         for (int i = 0; i < SLOTS; i++) slots[i] <= slots_nxt[i];
         rd_hit <= rd_match;
      end
   end

endmodule

// File: rtl/note_lane_engine.sv
// Note lane engine top: LANES lane instances, spawn acceptance, strum judging and scoring.
// Build option: NLE_STREAK_MULT_EN enables the streak-based score multiplier.
module note_lane_engine
   import nle_pkg::*;
#(
   parameter int LANES    = NLE_LANES,
   parameter int SLOTS    = NLE_SLOTS,
   parameter int NOTE_H   = NLE_NOTE_H,
   parameter int HIT_Y    = NLE_HIT_Y,
   parameter int HIT_H    = NLE_HIT_H,
   parameter int SCREEN_H = NLE_SCREEN_H
) (
   input logic  clk,
   input logic  reset,
   nle_if.slave bus
);

   logic [LANES-1:0] has_free;
   logic [LANES-1:0] win;
   logic [LANES-1:0] rdh;
   logic [LANES-1:0] fall;
   logic [LANES-1:0] hit_free;
   logic             xfer;
   logic             strum_hit;
   logic             strum_miss;
   logic             hit_pulse_q;
   logic             miss_pulse_q;
   logic [15:0]      score_q;
   logic [15:0]      score_nxt;
   logic [7:0]       streak_q;
   logic [7:0]       streak_nxt;
   logic [16:0]      score_sum;

   assign bus.spawn_ready = &(~bus.spawn_mask | has_free);
   assign xfer            = bus.spawn_valid && bus.spawn_ready;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      nle_lane #(
         .SLOTS(SLOTS), .NOTE_H(NOTE_H), .HIT_Y(HIT_Y), .HIT_H(HIT_H), .SCREEN_H(SCREEN_H)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .spawn     (xfer && bus.spawn_mask[l]),
         .frame_tick(bus.frame_tick),
         .speed     (bus.speed),
         .hit_free  (hit_free[l]),
         .rd_y      (bus.rd_y),
         .has_free  (has_free[l]),
         .in_window (win[l]),
         .rd_hit    (rdh[l]),
         .fall_off  (fall[l])
      );
   end

   // Strum is judged on the positions held before any same-cycle tick.
   assign strum_hit  = bus.strum && (|win) && (bus.buttons == win);
   assign strum_miss = bus.strum && (|win) && (bus.buttons != win);
   assign hit_free   = strum_hit ? win : '0;

   always_comb begin
      score_sum  = {1'b0, score_q} + {14'b0, mult_f(streak_q, NLE_MULT_EN)};
      score_nxt  = score_q;
      streak_nxt = streak_q;
      if (strum_hit) begin
         score_nxt  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         streak_nxt = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
      end
      if (strum_miss || (|fall))
         streak_nxt = 8'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         score_q      <= '0;
         streak_q     <= '0;
      end else begin
         hit_pulse_q  <= strum_hit;
         miss_pulse_q <= strum_miss || (|fall);
         score_q      <= score_nxt;
         streak_q     <= streak_nxt;
      end
   end

   assign bus.in_window  = win;
   assign bus.rd_hit     = rdh;
   assign bus.hit_pulse  = hit_pulse_q;
   assign bus.miss_pulse = miss_pulse_q;
   assign bus.score      = score_q;
   assign bus.streak     = streak_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed self-checking bench for note_lane_engine (default geometry, 4 lanes x 4 slots).
module tb_note_lane_engine;
   import nle_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_score;
   logic [7:0]  exp_streak;

   nle_if #(.LANES(4)) bus ();

   note_lane_engine #(.LANES(4), .SLOTS(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // drivers: inputs change 1ns after a rising edge, outputs are sampled at the same point
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   task automatic spawn(input logic [3:0] mask);
      bus.spawn_valid = 1'b1;
      bus.spawn_mask  = mask;
      idle(1);
      bus.spawn_valid = 1'b0;
      bus.spawn_mask  = '0;
   endtask

   task automatic tick(input int n);
      bus.frame_tick = 1'b1;
      idle(n);
      bus.frame_tick = 1'b0;
   endtask

   task automatic do_strum(input logic [3:0] btn, input logic with_tick);
      bus.strum      = 1'b1;
      bus.buttons    = btn;
      bus.frame_tick = with_tick;
      idle(1);
      bus.strum      = 1'b0;
      bus.buttons    = '0;
      bus.frame_tick = 1'b0;
   endtask

   task automatic rd_probe(input logic [9:0] y, input logic [3:0] exp_v, input string tag);
      bus.rd_y = y;
      idle(1);
      check(tag, bus.rd_hit, exp_v);
   endtask

   function automatic logic [15:0] model_mult(input logic [7:0] s);
`ifdef NLE_STREAK_MULT_EN
      return (s >= 30) ? 16'd4 : 16'(s / 10 + 1);
`else
      return 16'd1 + 16'(s & 8'd0);
`endif
   endfunction

   initial begin
      bus.frame_tick  = 1'b0;
      bus.speed       = 4'd0;
      bus.spawn_valid = 1'b0;
      bus.spawn_mask  = '0;
      bus.strum       = 1'b0;
      bus.buttons     = '0;
      bus.rd_y        = '0;
      #2;
      do_reset();

      // reset state
      check("rst_score", bus.score, 0);
      check("rst_streak", bus.streak, 0);
      check("rst_hit", bus.hit_pulse, 0);
      check("rst_miss", bus.miss_pulse, 0);
      check("rst_win", bus.in_window, 0);
      check("rst_rdhit", bus.rd_hit, 0);
      bus.spawn_mask = 4'b1111;
      #1 check("rst_ready", bus.spawn_ready, 1);
      bus.spawn_mask = '0;

      // single note reaches the bar after 100 ticks at speed 4 (y = 350)
      bus.speed = 4'd4;
      spawn(4'b0100);
      tick(100);
      check("win_lane2", bus.in_window, 4'b0100);
      rd_probe(10'd350, 4'b0100, "rd_top");
      rd_probe(10'd399, 4'b0100, "rd_bottom");
      rd_probe(10'd400, 4'b0000, "rd_past");
      do_strum(4'b0100, 1'b0);
      check("hit_pulse", bus.hit_pulse, 1);
      check("hit_nomiss", bus.miss_pulse, 0);
      check("hit_score", bus.score, 1);
      check("hit_streak", bus.streak, 1);
      check("hit_freed", bus.in_window, 0);
      idle(1);
      check("hit_onecycle", bus.hit_pulse, 0);
      do_strum(4'b0100, 1'b0);
      check("empty_strum_hit", bus.hit_pulse, 0);
      check("empty_strum_miss", bus.miss_pulse, 0);
      check("empty_strum_score", bus.score, 1);

      // chord with wrong buttons is a miss and frees nothing
      spawn(4'b0011);
      tick(100);
      check("chord_win", bus.in_window, 4'b0011);
      do_strum(4'b0001, 1'b0);
      check("chord_miss", bus.miss_pulse, 1);
      check("chord_nohit", bus.hit_pulse, 0);
      check("chord_streak", bus.streak, 0);
      check("chord_keep", bus.in_window, 4'b0011);
      check("chord_score", bus.score, 1);

      // render row match at y = 100
      do_reset();
      bus.speed = 4'd10;
      spawn(4'b0001);
      tick(15);
      rd_probe(10'd120, 4'b0001, "rd_120");
      rd_probe(10'd150, 4'b0000, "rd_150");
      rd_probe(10'd149, 4'b0001, "rd_149");
      rd_probe(10'd99, 4'b0000, "rd_99");
      rd_probe(10'd100, 4'b0001, "rd_100");

      // two notes in one lane window: the deeper one is freed
      do_reset();
      bus.speed = 4'd15;
      spawn(4'b0001);
      tick(1);
      spawn(4'b0001);
      tick(24);
      check("two_win", bus.in_window, 4'b0001);
      do_strum(4'b0001, 1'b0);
      check("two_hit", bus.hit_pulse, 1);
      check("two_keep", bus.in_window, 4'b0001);
      rd_probe(10'd362, 4'b0000, "two_deep_gone");
      rd_probe(10'd359, 4'b0001, "two_shallow_left");
      // strum and tick together: judged pre-tick, hit slot freed not moved
      do_strum(4'b0001, 1'b1);
      check("same_hit", bus.hit_pulse, 1);
      check("same_win", bus.in_window, 0);
      check("same_streak", bus.streak, 2);

      // full lane blocks spawn until a note falls off
      do_reset();
      bus.speed = 4'd15;
      spawn(4'b0010); tick(1);
      spawn(4'b0010); tick(1);
      spawn(4'b0010); tick(1);
      spawn(4'b0010);
      bus.spawn_mask = 4'b0010;
      #1 check("full_ready", bus.spawn_ready, 0);
      bus.spawn_mask = 4'b0001;
      #1 check("other_ready", bus.spawn_ready, 1);
      bus.spawn_mask = 4'b0000;
      #1 check("zero_ready", bus.spawn_ready, 1);
      tick(32);
      check("pre_fall_miss", bus.miss_pulse, 0);
      bus.spawn_mask = 4'b0010;
      #1 check("pre_fall_ready", bus.spawn_ready, 0);
      bus.spawn_mask = '0;
      tick(1);
      check("fall_miss", bus.miss_pulse, 1);
      bus.spawn_mask = 4'b0010;
      #1 check("fall_ready", bus.spawn_ready, 1);
      bus.spawn_mask = '0;
      idle(1);
      check("fall_onecycle", bus.miss_pulse, 0);

      // reset overrides same-cycle spawn, tick and strum
      do_reset();
      bus.speed = 4'd15;
      spawn(4'b1000);
      tick(24);
      bus.spawn_valid = 1'b1;
      bus.spawn_mask  = 4'b1111;
      bus.frame_tick  = 1'b1;
      bus.strum       = 1'b1;
      bus.buttons     = 4'b1000;
      reset           = 1'b1;
      idle(1);
      reset           = 1'b0;
      bus.spawn_valid = 1'b0;
      bus.spawn_mask  = '0;
      bus.frame_tick  = 1'b0;
      bus.strum       = 1'b0;
      bus.buttons     = '0;
      check("mid_rst_hit", bus.hit_pulse, 0);
      check("mid_rst_score", bus.score, 0);
      check("mid_rst_win", bus.in_window, 0);
      tick(24);
      check("mid_rst_nospawn", bus.in_window, 0);

      // consecutive hits accumulate score through the multiplier
      do_reset();
      bus.speed  = 4'd15;
      exp_score  = 0;
      exp_streak = 0;
      for (int k = 0; k < 12; k++) begin
         spawn(4'b1000);
         tick(24);
         do_strum(4'b1000, 1'b0);
         exp_q.push_back(exp_score + model_mult(exp_streak));
         exp_score  = exp_score + model_mult(exp_streak);
         exp_streak = exp_streak + 8'd1;
         check("run_score", bus.score, exp_q.pop_front());
         check("run_streak", bus.streak, exp_streak);
      end
`ifdef NLE_STREAK_MULT_EN
      check("run_total", bus.score, 14);
`else
      check("run_total", bus.score, 12);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
